imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_arbiter.sv | 109 ++++++++++
 tb/tb_imm_ext_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
// Two-requester round-robin arbiter in front of a shared immediate
// sign/zero extension unit. The winner's M-bit value is extended to N bits
// and held in a one-entry output register with valid/ready backpressure.
module imm_ext_arbiter #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [M-1:0] req0_data,
    input  logic         req0_zext,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [M-1:0] req1_data,
    input  logic         req1_zext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_src
);

    // Output register occupancy: EMPTY means out_data/out_src are stale.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_out_data;
    logic           r_out_src;
    logic           r_last;

    logic           w_accept;
    logic           w_grant;
    logic           w_hs;
    logic [M-1:0]   w_sel_data;
    logic           w_sel_zext;
    logic           w_fill;
    logic [N-1:0]   w_ext;

    // The output slot can take a new result when empty or draining this cycle.
    assign w_accept = (r_state == EMPTY) || out_ready;

    // Round-robin grant: a lone requester wins; on contention the one not
    // served last wins. Since r_last only moves on a handshake, a stalled
    // pending pair keeps the same grant for the whole stall.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Readies are forced low while reset is asserted so no handshake is
    // reported in a reset cycle.
    assign req0_ready = !rst && w_accept && !w_grant && req0_valid;
    assign req1_ready = !rst && w_accept &&  w_grant && req1_valid;
    assign w_hs       = req0_ready || req1_ready;

    // Extension of the granted value: fill bit is the MSB for sign-extend.
    assign w_sel_data = w_grant ? req1_data : req0_data;
    assign w_sel_zext = w_grant ? req1_zext : req0_zext;
    assign w_fill     = ~w_sel_zext & w_sel_data[M-1];
    assign w_ext      = {{(N-M){w_fill}}, w_sel_data};

    // Next occupancy: a handshake always fills (including pass-through while
    // draining); otherwise a consumed result empties the slot.
    always_comb begin
        w_state_next = r_state;
        if (w_hs) begin
            w_state_next = FULL;
        end else if (r_state == FULL && out_ready) begin
            w_state_next = EMPTY;
        end
    end

    // State register; a pending result is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result and arbitration pointer load only on an actual handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_src  <= 1'b0;
            r_last     <= 1'b1;
        end else if (w_hs) begin
            r_out_data <= w_ext;
            r_out_src  <= w_grant;
            r_last     <= w_grant;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed testbench for imm_ext_arbiter: default 32/16 instance plus a
// 16/8 instance for the parameter override case.
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance (N=32, M=16)
    logic        req0_valid, req0_ready, req0_zext;
    logic        req1_valid, req1_ready, req1_zext;
    logic [15:0] req0_data, req1_data;
    logic        out_valid, out_ready, out_src;
    logic [31:0] out_data;

    // Override instance (N=16, M=8)
    logic        p0_valid, p0_ready, p0_zext;
    logic        p1_valid, p1_ready, p1_zext;
    logic [7:0]  p0_data, p1_data;
    logic        p_out_valid, p_out_ready, p_out_src;
    logic [15:0] p_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_ext_arbiter #(.N(32), .M(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_zext(req0_zext),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_zext(req1_zext),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    imm_ext_arbiter #(.N(16), .M(8)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(p0_valid), .req0_ready(p0_ready),
        .req0_data(p0_data), .req0_zext(p0_zext),
        .req1_valid(p1_valid), .req1_ready(p1_ready),
        .req1_data(p1_data), .req1_zext(p1_zext),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_data(p_out_data), .out_src(p_out_src)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h1234; req0_zext = 1'b0;
        req1_valid = 1'b1; req1_data = 16'h5678; req1_zext = 1'b0;
        out_ready = 1'b1;
        p0_valid = 1'b0; p0_data = 8'h00; p0_zext = 1'b0;
        p1_valid = 1'b0; p1_data = 8'h00; p1_zext = 1'b0;
        p_out_ready = 1'b1;
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL reset_src got %b exp 0", out_src); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
        $display("reset: valid=%b data=%h readies=%b", out_valid, out_data, {req0_ready, req1_ready});
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sign_ext();
        req0_valid = 1'b1; req0_data = 16'h8001; req0_zext = 1'b0;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sext_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'hFFFF8001) begin errors++; $display("FAIL sext_data got %h exp ffff8001", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL sext_src got %b exp 0", out_src); end
        $display("sext: src=%b data=%h", out_src, out_data);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'hFFFF8001) begin errors++; $display("FAIL drain_hold got %h exp ffff8001", out_data); end
    endtask

    task automatic test_back_to_back();
        req1_valid = 1'b1; req1_data = 16'h8001; req1_zext = 1'b1;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL b2b_ready0 got %b exp 01", {req0_ready, req1_ready}); end
        tick();
        checks++; if (out_data !== 32'h00008001 || out_src !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 00008001/1", out_data, out_src); end
        $display("b2b: src=%b data=%h", out_src, out_data);
        req1_data = 16'h7FFF; req1_zext = 1'b0;
        #2;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_passthru_ready got %b exp 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'h00007FFF || out_src !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp 00007fff/1", out_data, out_src); end
        $display("b2b: src=%b data=%h", out_src, out_data);
        tick();
    endtask

    task automatic test_alternation();
        logic exp_g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h0001; req0_zext = 1'b1;
        req1_valid = 1'b1; req1_data = 16'h0002; req1_zext = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            #2;
            checks++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin errors++; $display("FAIL alt_ready[%0d] got %b exp %b", i, {req0_ready, req1_ready}, {~exp_g, exp_g}); end
            tick();
            checks++; if (out_src !== exp_g || out_data !== (exp_g ? 32'h2 : 32'h1) || out_valid !== 1'b1) begin errors++; $display("FAIL alt_out[%0d] got %b/%h/%b exp %b", i, out_src, out_data, out_valid, exp_g); end
            $display("alt[%0d]: src=%b data=%h", i, out_src, out_data);
        end
    endtask

    task automatic test_stall();
        // Last grant was requester 1, so requester 0 wins next.
        tick();
        checks++; if (out_src !== 1'b0 || out_data !== 32'h1) begin errors++; $display("FAIL stall_pre got %b/%h exp 0/00000001", out_src, out_data); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 00", i, {req0_ready, req1_ready}); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h1 || out_src !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h/%b exp 1/00000001/0", i, out_valid, out_data, out_src); end
            $display("stall[%0d]: valid=%b data=%h", i, out_valid, out_data);
        end
        out_ready = 1'b1;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL resume_ready got %b exp 01", {req0_ready, req1_ready}); end
        tick();
        checks++; if (out_src !== 1'b1 || out_data !== 32'h2) begin errors++; $display("FAIL resume_out got %b/%h exp 1/00000002", out_src, out_data); end
        $display("resume: src=%b data=%h", out_src, out_data);
        tick();
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL resume_next got %b exp 0", out_src); end
    endtask

    task automatic test_reset_mid();
        // Pointer now favours requester 1; reset must restore requester 0.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rstmid_out got %b/%h exp 0/00000000", out_valid, out_data); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_ready got %b exp 00", {req0_ready, req1_ready}); end
        $display("reset mid: valid=%b data=%h", out_valid, out_data);
        tick();
        rst = 1'b0;
        #2;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_grant got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        checks++; if (out_src !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_src got %b/%b exp 0/1", out_src, out_valid); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_param();
        p0_valid = 1'b1; p0_data = 8'h80; p0_zext = 1'b0;
        #2;
        checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL p_ready got %b exp 1", p0_ready); end
        tick();
        checks++; if (p_out_data !== 16'hFF80) begin errors++; $display("FAIL p_sext got %h exp ff80", p_out_data); end
        $display("param sext: data=%h", p_out_data);
        p0_zext = 1'b1;
        tick();
        p0_valid = 1'b0;
        checks++; if (p_out_data !== 16'h0080 || p_out_valid !== 1'b1) begin errors++; $display("FAIL p_zext got %h/%b exp 0080/1", p_out_data, p_out_valid); end
        $display("param zext: data=%h", p_out_data);
        tick();
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_back_to_back();
        test_alternation();
        test_stall();
        test_reset_mid();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
